// File: rtl/package_settings.sv
// Data-path widths shared across the ADC processing chain.
package package_settings;

    localparam int SIZE_ADC_DATA    = 12;
    localparam int SIZE_FILTER_DATA = 12;

endpackage

// File: rtl/trapezoid_filter_parameters.sv
// Defaults, shared types and the configuration legality rule for the programmable trapezoid shaper.
package trapezoid_filter_parameters;

    localparam int DEFAULT_MAX_DEPTH   = 64;
    localparam int DEFAULT_ACC_WIDTH   = 32;
    localparam int DEFAULT_M_WIDTH     = 10;
    localparam int DEFAULT_SHIFT_WIDTH = 5;

    typedef logic signed [DEFAULT_ACC_WIDTH-1:0] acc_t;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } fill_state_t;

    function automatic logic cfg_legal(input int k, input int l, input int max_depth);
        return (k >= 1) && (k <= l) && (k + l <= max_depth);
    endfunction

endpackage

// File: rtl/trapezoid_delay_line.sv
// Circular sample history with fill tracking; presents x(n), x(n-k), x(n-l), x(n-k-l),
// reading zero for any tap older than the samples seen since the last clear.
module trapezoid_delay_line
    import package_settings::*, trapezoid_filter_parameters::*;
#(
    parameter int  MAX_DEPTH = DEFAULT_MAX_DEPTH,
    localparam int LEN_W     = $clog2(MAX_DEPTH + 1),
    localparam int PTR_W     = $clog2(MAX_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_i,
    input  logic                     accept_i,
    input  logic [SIZE_ADC_DATA-1:0] sample_i,
    input  logic [LEN_W-1:0]         k_i,
    input  logic [LEN_W-1:0]         l_i,
    output logic [SIZE_ADC_DATA-1:0] x_n_o,
    output logic [SIZE_ADC_DATA-1:0] x_nk_o,
    output logic [SIZE_ADC_DATA-1:0] x_nl_o,
    output logic [SIZE_ADC_DATA-1:0] x_nkl_o,
    output logic                     settled_o
);

    logic [SIZE_ADC_DATA-1:0] mem_q [MAX_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q;
    logic [LEN_W-1:0]         fill_cnt_q;
    logic [LEN_W-1:0]         fill_next;
    logic [LEN_W-1:0]         span;
    fill_state_t              state_q;

    // The slot about to be overwritten still holds x(n-MAX_DEPTH), so a tap of MAX_DEPTH is valid.
    function automatic logic [SIZE_ADC_DATA-1:0] tap(input logic [LEN_W-1:0] t);
        int idx;
        idx = int'(wr_ptr_q) - int'(t);
        if (idx < 0) idx += MAX_DEPTH;
        return (fill_cnt_q >= t) ? mem_q[idx[PTR_W-1:0]] : '0;
    endfunction

    assign fill_next = fill_cnt_q + LEN_W'(1);
    assign span      = k_i + l_i;
    assign x_n_o     = sample_i;
    assign x_nk_o    = tap(k_i);
    assign x_nl_o    = tap(l_i);
    assign x_nkl_o   = tap(span);
    assign settled_o = (state_q == RUN) || (fill_next == span);

    // NOTE: history storage has no reset; stale entries are masked by fill_cnt_q until rewritten.
    always_ff @(posedge clk) begin
        if (accept_i && !clear_i) mem_q[wr_ptr_q] <= sample_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            state_q    <= FILL;
        end else if (clear_i) begin
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            state_q    <= FILL;
        end else if (accept_i) begin
            wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            case (state_q)
                FILL: begin
                    fill_cnt_q <= fill_next;
                    if (fill_next == span) state_q <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end

endmodule

// File: rtl/trapezoid_filter_prog.sv
// Runtime-programmable trapezoidal pulse shaper: d/p/r/s recursion over a circular history,
// arithmetic output shift and clip to the unsigned filter width, with fill/settle tracking.
module trapezoid_filter_prog
    import package_settings::*, trapezoid_filter_parameters::*;
#(
    parameter int  MAX_DEPTH   = DEFAULT_MAX_DEPTH,
    parameter int  ACC_WIDTH   = DEFAULT_ACC_WIDTH,
    parameter int  M_WIDTH     = DEFAULT_M_WIDTH,
    parameter int  SHIFT_WIDTH = DEFAULT_SHIFT_WIDTH,
    localparam int LEN_W       = $clog2(MAX_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SIZE_ADC_DATA-1:0]    in_data,
    input  logic                        in_valid,
    input  logic [LEN_W-1:0]            cfg_k,
    input  logic [LEN_W-1:0]            cfg_l,
    input  logic [M_WIDTH-1:0]          cfg_m,
    input  logic [SHIFT_WIDTH-1:0]      cfg_shift,
    input  logic                        cfg_load,
    output logic [SIZE_FILTER_DATA-1:0] out_data,
    output logic                        out_valid,
    output logic                        out_settled,
    output logic                        out_sat,
    output logic                        cfg_err
);

    logic [LEN_W-1:0]       k_q, l_q;
    logic [M_WIDTH-1:0]     m_q;
    logic [SHIFT_WIDTH-1:0] shift_q;
    logic                   cfg_err_q;
    logic                   load_ok, accept, settled;
    logic [SIZE_ADC_DATA-1:0] x_n, x_nk, x_nl, x_nkl;

    assign load_ok = cfg_load && cfg_legal(int'(cfg_k), int'(cfg_l), MAX_DEPTH);
    assign accept  = in_valid && !load_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_q       <= LEN_W'(1);
            l_q       <= LEN_W'(2);
            m_q       <= '0;
            shift_q   <= '0;
            cfg_err_q <= 1'b0;
        end else if (cfg_load) begin
            cfg_err_q <= !load_ok;
            if (load_ok) begin
                k_q     <= cfg_k;
                l_q     <= cfg_l;
                m_q     <= cfg_m;
                shift_q <= cfg_shift;
            end
        end
    end

    trapezoid_delay_line #(.MAX_DEPTH(MAX_DEPTH)) u_delay (
        .clk       (clk),
        .rst_n     (reset),
        .clear_i   (load_ok),
        .accept_i  (accept),
        .sample_i  (in_data),
        .k_i       (k_q),
        .l_i       (l_q),
        .x_n_o     (x_n),
        .x_nk_o    (x_nk),
        .x_nl_o    (x_nl),
        .x_nkl_o   (x_nkl),
        .settled_o (settled)
    );

    logic signed [ACC_WIDTH-1:0] d_d, d_q, d2_q, p_q, r_q, s_q, m_ext, v;
    logic [SIZE_FILTER_DATA-1:0] clip_d, out_data_q;
    logic                        sat_d, out_sat_q, out_valid_q, out_settled_q;
    logic                        v1_q, v2_q, v3_q, v4_q, set1_q, set2_q, set3_q, set4_q;

    assign d_d   = ACC_WIDTH'(x_n) - ACC_WIDTH'(x_nk) - ACC_WIDTH'(x_nl) + ACC_WIDTH'(x_nkl);
    assign m_ext = ACC_WIDTH'(m_q);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        v      = s_q >>> shift_q;
        clip_d = '0;
        sat_d  = 1'b1;
        if (v[ACC_WIDTH-1]) begin
            clip_d = '0;
        end else if (|v[ACC_WIDTH-2:SIZE_FILTER_DATA]) begin
            clip_d = '1;
        end else begin
            clip_d = v[SIZE_FILTER_DATA-1:0];
            sat_d  = 1'b0;
        end
    end

    // Valid bits travel with each sample; accumulators advance only on their stage's valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {v1_q, v2_q, v3_q, v4_q}         <= '0;
            {set1_q, set2_q, set3_q, set4_q} <= '0;
            d_q <= '0; d2_q <= '0; p_q <= '0; r_q <= '0; s_q <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_sat_q     <= 1'b0;
            out_settled_q <= 1'b0;
        end else if (load_ok) begin
            {v1_q, v2_q, v3_q, v4_q} <= '0;
            p_q           <= '0;
            s_q           <= '0;
            out_valid_q   <= 1'b0;
            out_settled_q <= 1'b0;
        end else begin
            v1_q   <= accept;
            set1_q <= settled;
            if (accept) d_q <= d_d;
            v2_q   <= v1_q;
            set2_q <= set1_q;
            if (v1_q) begin
                p_q  <= p_q + d_q;
                d2_q <= d_q;
            end
            v3_q   <= v2_q;
            set3_q <= set2_q;
            if (v2_q) r_q <= p_q + m_ext * d2_q;
            v4_q   <= v3_q;
            set4_q <= set3_q;
            if (v3_q) s_q <= s_q + r_q;
            out_valid_q <= v4_q;
            if (v4_q) begin
                out_data_q    <= clip_d;
                out_sat_q     <= sat_d;
                out_settled_q <= set4_q;
            end
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_sat     = out_sat_q;
    assign out_settled = out_settled_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_trapezoid_filter_prog.sv
// Scoreboard bench for trapezoid_filter_prog: a behavioural d/p/r/s model queues expected outputs
// per accepted sample; a negedge monitor pops and compares whenever out_valid is seen.
module tb_trapezoid_filter_prog;
    import package_settings::*;
    import trapezoid_filter_parameters::*;

    localparam int MAXD    = DEFAULT_MAX_DEPTH;
    localparam int LW      = $clog2(MAXD + 1);
    localparam int OUT_MAX = (1 << SIZE_FILTER_DATA) - 1;

    logic                             clk = 1'b0;
    logic                             reset = 1'b0;
    logic [SIZE_ADC_DATA-1:0]         in_data = '0;
    logic                             in_valid = 1'b0;
    logic [LW-1:0]                    cfg_k = '0;
    logic [LW-1:0]                    cfg_l = '0;
    logic [DEFAULT_M_WIDTH-1:0]       cfg_m = '0;
    logic [DEFAULT_SHIFT_WIDTH-1:0]   cfg_shift = '0;
    logic                             cfg_load = 1'b0;
    logic [SIZE_FILTER_DATA-1:0]      out_data;
    logic                             out_valid, out_settled, out_sat, cfg_err;

    trapezoid_filter_prog dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .cfg_k       (cfg_k),
        .cfg_l       (cfg_l),
        .cfg_m       (cfg_m),
        .cfg_shift   (cfg_shift),
        .cfg_load    (cfg_load),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_settled (out_settled),
        .out_sat     (out_sat),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SIZE_FILTER_DATA-1:0] data;
        logic                        sat;
        logic                        settled;
    } exp_t;

    exp_t  exp_q[$];
    int    hist[$];
    acc_t  mp, ms;
    int    mk = 1, ml = 2, mm = 0, msh = 0;
    int    n_compared = 0;
    int    n_mismatched = 0;
    bit    mon_en = 1'b0;
    string tag = "init";

    function automatic int xat(input int t);
        if (t > hist.size() - 1) return 0;
        return hist[hist.size() - 1 - t];
    endfunction

    task automatic model_reset(input int k, input int l, input int m, input int sh);
        hist.delete();
        mp = '0; ms = '0;
        mk = k; ml = l; mm = m; msh = sh;
    endtask

    task automatic model_accept(input int x, input bit push);
        acc_t d, r, v;
        exp_t e;
        hist.push_back(x);
        d  = acc_t'(xat(0) - xat(mk) - xat(ml) + xat(mk + ml));
        mp = mp + d;
        r  = mp + acc_t'(mm) * d;
        ms = ms + r;
        v  = ms >>> msh;
        if (v < 0) begin
            e.data = '0; e.sat = 1'b1;
        end else if (v > OUT_MAX) begin
            e.data = '1; e.sat = 1'b1;
        end else begin
            e.data = v[SIZE_FILTER_DATA-1:0]; e.sat = 1'b0;
        end
        e.settled = (hist.size() >= mk + ml);
        if (push) exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && reset && out_valid) begin
            n_compared++;
            if (exp_q.size() == 0) begin
                n_mismatched++;
                $display("FAIL %s unexpected_output: out_valid with data=%0d, expected no output", tag, out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e.data || out_sat !== e.sat || out_settled !== e.settled) begin
                    n_mismatched++;
                    $display("FAIL %s scoreboard: got data=%0d sat=%0b settled=%0b, expected data=%0d sat=%0b settled=%0b",
                             tag, out_data, out_sat, out_settled, e.data, e.sat, e.settled);
                end
            end
        end
    end

    task automatic send(input bit v, input int x, input bit push = 1'b1);
        @(negedge clk);
        in_valid = v;
        in_data  = SIZE_ADC_DATA'(x);
        if (v) model_accept(x, push);
        @(posedge clk);
    endtask

    task automatic drain(input string what);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL drain_%s: %0d outputs still pending, expected 0", what, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_load(input int k, input int l, input int m, input int sh, input bit v, input int x);
        bit legal;
        legal = cfg_legal(k, l, MAXD);
        @(negedge clk);
        cfg_k = LW'(k); cfg_l = LW'(l); cfg_m = DEFAULT_M_WIDTH'(m); cfg_shift = DEFAULT_SHIFT_WIDTH'(sh);
        cfg_load = 1'b1;
        in_valid = v;
        in_data  = SIZE_ADC_DATA'(x);
        if (legal) begin
            model_reset(k, l, m, sh);
            exp_q.delete();
        end else if (v) begin
            model_accept(x, 1'b1);
        end
        @(negedge clk);
        cfg_load = 1'b0;
        in_valid = 1'b0;
        n_compared++;
        if (cfg_err !== !legal) begin
            n_mismatched++;
            $display("FAIL %s cfg_err after load k=%0d l=%0d: got %0b, expected %0b", tag, k, l, cfg_err, !legal);
        end
    endtask

    task automatic test_reset();
        tag = "reset";
        #12;
        n_compared++;
        if (out_data !== '0) begin n_mismatched++; $display("FAIL reset out_data: got %0d, expected 0", out_data); end
        n_compared++;
        if (out_valid !== 1'b0) begin n_mismatched++; $display("FAIL reset out_valid: got %0b, expected 0", out_valid); end
        n_compared++;
        if (out_settled !== 1'b0) begin n_mismatched++; $display("FAIL reset out_settled: got %0b, expected 0", out_settled); end
        n_compared++;
        if (out_sat !== 1'b0) begin n_mismatched++; $display("FAIL reset out_sat: got %0b, expected 0", out_sat); end
        n_compared++;
        if (cfg_err !== 1'b0) begin n_mismatched++; $display("FAIL reset cfg_err: got %0b, expected 0", cfg_err); end
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        model_reset(1, 2, 0, 0);
        // Default config straight out of reset: k=1, l=2, M=0.
        send(1, 50);
        send(1, 0);
        send(1, 0);
        send(1, 0);
        drain("reset_default");
    endtask

    task automatic test_step();
        tag = "step";
        do_load(2, 4, 0, 0, 1'b0, 0);
        send(1, 0);
        repeat (12) send(1, 10);
        drain("step");
        tag = "step_k_eq_l";
        do_load(3, 3, 1, 2, 1'b0, 0);
        for (int i = 0; i < 10; i++) send(1, (i * 300) % 4096);
        repeat (8) send(1, 0);
        drain("step_k_eq_l");
    endtask

    task automatic test_impulse();
        int   dat[6] = '{32, 8, 0, 0, 0, 0};
        bit   sat[6] = '{0, 0, 1, 0, 0, 0};
        bit   stl[6] = '{0, 0, 1, 1, 1, 1};
        exp_t e;
        tag = "impulse";
        do_load(1, 2, 3, 0, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            e.data = SIZE_FILTER_DATA'(dat[i]); e.sat = sat[i]; e.settled = stl[i];
            exp_q.push_back(e);
        end
        send(1, 8, 1'b0);
        repeat (5) send(1, 0, 1'b0);
        drain("impulse");
    endtask

    task automatic test_bubbles();
        tag = "bubbles";
        do_load(2, 4, 0, 0, 1'b0, 0);
        send(1, 0);
        send(0, 0);
        for (int i = 0; i < 12; i++) begin
            send(1, 10);
            send(0, 77);
        end
        drain("bubbles");
    endtask

    task automatic test_config();
        tag = "config";
        do_load(2, 4, 0, 0, 1'b0, 0);
        repeat (10) send(1, 5);
        drain("config_pre");
        do_load(5, 3, 7, 1, 1'b1, 9);
        do_load(0, 4, 7, 1, 1'b0, 0);
        do_load(40, 40, 7, 1, 1'b0, 0);
        for (int i = 0; i < 8; i++) send(1, 20 * i);
        drain("config_old_active");
        send(1, 1000);
        send(1, 2000);
        do_load(2, 4, 0, 0, 1'b1, 4000);
        n_compared++;
        if (out_settled !== 1'b0) begin
            n_mismatched++;
            $display("FAIL config out_settled after legal load: got %0b, expected 0", out_settled);
        end
        repeat (6) @(negedge clk);
        send(1, 0);
        repeat (12) send(1, 10);
        drain("config_history_zeroed");
    endtask

    task automatic test_overflow();
        int shifts[3] = '{4, 8, 20};
        tag = "overflow";
        for (int j = 0; j < 3; j++) begin
            do_load(16, 16, 0, shifts[j], 1'b0, 0);
            repeat (40) send(1, 4095);
            drain("overflow");
        end
        tag = "max_depth";
        do_load(32, 32, 5, 10, 1'b0, 0);
        for (int i = 0; i < 150; i++) send(($urandom_range(0, 3) != 0), int'($urandom_range(0, 4095)));
        drain("max_depth");
    endtask

    task automatic test_reset_mid();
        int lat;
        tag = "reset_mid";
        do_load(3, 5, 2, 0, 1'b0, 0);
        for (int i = 0; i < 6; i++) send(1, 100 + 50 * i);
        do_load(9, 2, 0, 0, 1'b0, 0);
        send(1, 300);
        send(1, 300);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        reset  = 1'b0;
        in_valid = 1'b0;
        #1;
        n_compared++;
        if ({out_data, out_valid, out_settled, out_sat, cfg_err} !== '0) begin
            n_mismatched++;
            $display("FAIL reset_mid outputs: got data=%0d valid=%0b settled=%0b sat=%0b err=%0b, expected all 0",
                     out_data, out_valid, out_settled, out_sat, cfg_err);
        end
        exp_q.delete();
        model_reset(1, 2, 0, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        mon_en = 1'b1;
        repeat (6) @(negedge clk);
        in_valid = 1'b1;
        in_data  = SIZE_ADC_DATA'(200);
        model_accept(200, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid && lat == 0) lat = i;
        end
        n_compared++;
        if (lat != 4) begin
            n_mismatched++;
            $display("FAIL reset_mid latency: got %0d cycles, expected 4", lat);
        end
        drain("reset_mid");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_step();
        test_impulse();
        test_bubbles();
        test_config();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
